// File: rtl/memory_round_ctrl.sv
// Memory-game round controller: shows an LFSR pattern for one timer interval,
// opens a timed recall window, judges the guess and tracks score, lives and
// difficulty. The difficulty is fed back to the countdown timer as its reload.
module memory_round_ctrl #(
    parameter int unsigned RECONFIG_INIT = 12,
    parameter int unsigned RECONFIG_MIN  = 2,
    parameter int unsigned RECONFIG_STEP = 2,
    parameter int unsigned MAX_LIVES     = 3,
    parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] guess,
    input  logic       guess_valid,
    input  logic       time_out,
    output logic       time_in,
    output logic [3:0] reconfig,
    output logic [3:0] pattern_out,
    output logic       show,
    output logic [7:0] score,
    output logic [1:0] lives,
    output logic       result_ok,
    output logic       result_fail,
    output logic       game_over
);

    localparam logic [3:0] ReconfigInit = 4'(RECONFIG_INIT);
    localparam logic [3:0] ReconfigMin  = 4'(RECONFIG_MIN);
    localparam logic [3:0] ReconfigStep = 4'(RECONFIG_STEP);
    localparam logic [1:0] LivesInit    = 2'(MAX_LIVES);
    // Smallest reload that can still be stepped down without going below the floor.
    localparam logic [4:0] StepFloor    = 5'(RECONFIG_MIN + RECONFIG_STEP);

    typedef enum logic [2:0] {
        StIdle,
        StArmShow,
        StShow,
        StArmRecall,
        StRecall,
        StJudge,
        StOver
    } state_e;

    state_e     state;
    logic [7:0] lfsr;
    logic       hit;

    logic [7:0] lfsr_next;
    logic [3:0] reconfig_fast;
    logic [7:0] score_inc;
    logic       guess_match;

    // Next-value helpers: LFSR step, sped-up reload and saturating score.
    always_comb begin
        lfsr_next   = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        guess_match = (guess == pattern_out);
        if ({1'b0, reconfig} >= StepFloor) begin
            reconfig_fast = reconfig - ReconfigStep;
        end else begin
            reconfig_fast = ReconfigMin;
        end
        if (score == 8'hFF) begin
            score_inc = score;
        end else begin
            score_inc = score + 8'd1;
        end
    end

    // Round FSM; every output is a register updated on the edge entering its state.
    always_ff @(posedge clock) begin
        if (rst) begin
            state       <= StIdle;
            lfsr        <= LFSR_SEED;
            hit         <= 1'b0;
            time_in     <= 1'b0;
            show        <= 1'b0;
            pattern_out <= 4'd0;
            score       <= 8'd0;
            lives       <= LivesInit;
            reconfig    <= ReconfigInit;
            result_ok   <= 1'b0;
            result_fail <= 1'b0;
            game_over   <= 1'b0;
        end else begin
            lfsr        <= lfsr_next;
            time_in     <= 1'b0;
            result_ok   <= 1'b0;
            result_fail <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (start) begin
                        state       <= StArmShow;
                        pattern_out <= lfsr[3:0];
                        time_in     <= 1'b1;
                        show        <= 1'b1;
                    end
                end

                StArmShow: begin
                    state <= StShow;
                end

                StShow: begin
                    if (time_out) begin
                        state   <= StArmRecall;
                        show    <= 1'b0;
                        time_in <= 1'b1;
                    end
                end

                StArmRecall: begin
                    state <= StRecall;
                end

                StRecall: begin
                    // A guess in the same cycle as the timeout takes priority.
                    if (guess_valid) begin
                        state       <= StJudge;
                        hit         <= guess_match;
                        result_ok   <= guess_match;
                        result_fail <= !guess_match;
                    end else if (time_out) begin
                        state       <= StJudge;
                        hit         <= 1'b0;
                        result_fail <= 1'b1;
                    end
                end

                StJudge: begin
                    if (hit) begin
                        score       <= score_inc;
                        reconfig    <= reconfig_fast;
                        state       <= StArmShow;
                        pattern_out <= lfsr[3:0];
                        time_in     <= 1'b1;
                        show        <= 1'b1;
                    end else begin
                        lives <= lives - 2'd1;
                        if (lives == 2'd1) begin
                            state     <= StOver;
                            game_over <= 1'b1;
                        end else begin
                            state       <= StArmShow;
                            pattern_out <= lfsr[3:0];
                            time_in     <= 1'b1;
                            show        <= 1'b1;
                        end
                    end
                end

                StOver: begin
                    if (start) begin
                        score       <= 8'd0;
                        lives       <= LivesInit;
                        reconfig    <= ReconfigInit;
                        game_over   <= 1'b0;
                        state       <= StArmShow;
                        pattern_out <= lfsr[3:0];
                        time_in     <= 1'b1;
                        show        <= 1'b1;
                    end
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
